// File: rtl/pipe_add_12b.sv
// pipe_add_12b: carry-pipelined W-bit adder built from N_SLICES 3-bit CLA slices, one register stage per slice.
// Define ADD_OVF_EN to build the registered signed-overflow output ovf; otherwise ovf is tied to 0.
module pipe_add_12b #(
  parameter int N_SLICES = 4,
  localparam int W = 3 * N_SLICES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         co,
  output logic         ovf
);
  function automatic logic [3:0] cla_3b(input logic [2:0] x, input logic [2:0] y, input logic c);
    logic [2:0] g, p, cc;
    g = x & y;
    p = x ^ y;
    cc[0] = c;
    cc[1] = g[0] | (p[0] & c);
    cc[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    return {g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (&p & c), p ^ cc};
  endfunction
  logic                adv;
  logic [W-1:0]        a_q [N_SLICES];
  logic [W-1:0]        b_q [N_SLICES];
  logic [W-1:0]        s_q [N_SLICES];
  logic [W-1:0]        a_d [N_SLICES];
  logic [W-1:0]        b_d [N_SLICES];
  logic [W-1:0]        s_d [N_SLICES];
  logic [N_SLICES-1:0] v_q, v_d, c_q, c_d, ci;
  assign adv       = !v_q[N_SLICES-1] | out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[N_SLICES-1];
  assign sum       = s_q[N_SLICES-1];
  assign co        = c_q[N_SLICES-1];
  assign v_d       = {v_q[N_SLICES-2:0], in_valid};
  assign ci        = {c_q[N_SLICES-2:0], cin};
  // Stage k adds its own slice on top of what stage k-1 registered; lower sum bits ride along untouched
  always_comb begin
    c_d    = '0;
    a_d[0] = a;
    b_d[0] = b;
    s_d[0] = '0;
    for (int k = 1; k < N_SLICES; k++) begin
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
      s_d[k] = s_q[k-1];
    end
    for (int k = 0; k < N_SLICES; k++)
      {c_d[k], s_d[k][3*k+:3]} = cla_3b(a_d[k][3*k+:3], b_d[k][3*k+:3], ci[k]);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v_q <= '0;
      c_q <= '0;
      a_q <= '{default: '0};
      b_q <= '{default: '0};
      s_q <= '{default: '0};
    end else if (adv) begin
      v_q <= v_d;
      c_q <= c_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
    end
`ifdef ADD_OVF_EN
  logic cm_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cm_q <= 1'b0;
    else if (adv) cm_q <= a_d[N_SLICES-1][W-1] ^ b_d[N_SLICES-1][W-1] ^ s_d[N_SLICES-1][W-1];
  assign ovf = cm_q ^ c_q[N_SLICES-1];
`else
  assign ovf = 1'b0;
`endif
endmodule
